// File: rtl/fp_div_pkg.sv
// fp_div_pkg
//   Shared constants and the controller state type for the mantissa divider.
//   MANT_W : mantissa width including the hidden bit
//   Q_W    : quotient bits produced (1 integer + Q_W-1 fractional)
package fp_div_pkg;

  localparam int MANT_W = 24;
  localparam int Q_W    = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fp_mant_divider_ripple_sub.sv
// full_adder / ripple_sub
//   Combinational N-bit borrow-ripple subtractor: diff = a - b.
//   Built as a + ~b + 1 over a chain of full_adder cells.
//   Ports (ripple_sub):
//     a, b       : N-bit operands
//     diff       : N-bit difference (mod 2^N)
//     borrow_out : 1 when a < b (unsigned)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module ripple_sub #(
  parameter int N = 26
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  logic [N:0] carry;

  // Carry-in of 1 plus inverted b forms the two's complement of b.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  // A final carry of 1 means no borrow occurred.
  assign borrow_out = ~carry[N];

endmodule

// File: rtl/fp_mant_divider.sv
// fp_mant_divider
//   Iterative restoring divider for normalized mantissas; one quotient bit
//   per cycle, MSB (weight 2^0) first.
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; the producer holds valid (and data) until that edge, and the
//   block holds out_valid and its result stable until out_ready is seen.
//   Ports:
//     clk, rst_n            : clock, synchronous active-low reset
//     in_valid / in_ready   : operand handshake (ready only in IDLE)
//     dividend, divisor     : MANT_W-bit mantissas, divisor may be zero
//     out_valid / out_ready : result handshake
//     quotient              : Q_W-bit A/B, bit Q_W-1 has weight 2^0
//     sticky                : final remainder nonzero
//     div_by_zero           : divisor was zero (quotient forced to 0)
module fp_mant_divider
  import fp_div_pkg::*;
#(
  parameter int MANT_W = fp_div_pkg::MANT_W,
  parameter int Q_W    = fp_div_pkg::Q_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] dividend,
  input  logic [MANT_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Q_W-1:0]    quotient,
  output logic              sticky,
  output logic              div_by_zero
);

  localparam int REM_W = MANT_W + 2;
  localparam int CNT_W = $clog2(Q_W);

  state_e            state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [MANT_W-1:0] dsr_q, dsr_d;
  logic [Q_W-1:0]    quo_q, quo_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sticky_q, sticky_d;
  logic              dbz_q, dbz_d;

  logic [REM_W-1:0]  diff;
  logic              borrow;
  logic [REM_W-1:0]  rem_keep;

  ripple_sub #(.N(REM_W)) u_sub (
    .a          (rem_q),
    .b          ({2'b00, dsr_q}),
    .diff       (diff),
    .borrow_out (borrow)
  );

  // Restoring step: keep the difference only if it did not go negative.
  assign rem_keep = borrow ? rem_q : diff;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    quo_d    = quo_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d    = {2'b00, dividend};
          dsr_d    = divisor;
          quo_d    = '0;
          count_d  = CNT_W'(Q_W - 1);
          sticky_d = 1'b0;
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        // Quotient bits enter at the LSB so the first one ends at bit Q_W-1.
        quo_d = {quo_q[Q_W-2:0], ~borrow};
        rem_d = {rem_keep[REM_W-2:0], 1'b0};
        if (count_q == '0) begin
          sticky_d = (rem_keep != '0);
          state_d  = DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      dsr_q    <= '0;
      quo_q    <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      quo_q    <= quo_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      dbz_q    <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign sticky      = sticky_q;
  assign div_by_zero = dbz_q;

endmodule
